nios_system_4_mem_copier: RTL and testbench
===========================================

NIOS_SYSTEM_4_MEM_COPIER -- requirements
Module: nios_system_4_mem_copier

Interface
REQ-001 SHALL have parameter DEPTH, default 10240, number of 32-bit words in the target memory.
REQ-002 SHALL have parameter ADDR_W, default 14, word-address width.
REQ-003 SHALL have one clock and an asynchronous active-low reset, as below.
REQ-004 clk  in  1  sole clock; all logic on its rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  one-cycle request to begin a copy.
REQ-007 src_addr  in  ADDR_W  first source word address.
REQ-008 dst_addr  in  ADDR_W  first destination word address.
REQ-009 length  in  ADDR_W  number of words to copy; 0 is legal.
REQ-010 busy  out  1  copy in progress.
REQ-011 done  out  1  one-cycle completion pulse.
REQ-012 error  out  1  one-cycle range-error pulse, coincident with done.
REQ-013 m_address  out  ADDR_W  Avalon-MM initiator word address to the on-chip memory slave.
REQ-014 m_byteenable  out  4  byte lanes; constant 4'hF.
REQ-015 m_chipselect  out  1  bus access strobe.
REQ-016 m_write  out  1  write qualifier; a read is chipselect=1 with write=0.
REQ-017 m_writedata  out  32  write data.
REQ-018 m_clken  out  1  memory clock enable; constant 1.
REQ-019 m_readdata  in  32  read data; valid in the cycle after the read cycle (fixed latency 1, no waitrequest).

Function
REQ-020 SHALL implement an FSM with states IDLE, READ, CAPTURE, WRITE, FINISH.
REQ-021 In IDLE, start=1 SHALL latch src_addr, dst_addr and length.
REQ-022 On that start, the FSM SHALL go to FINISH with error=0 when length=0.
REQ-023 On that start, the FSM SHALL go to FINISH with error=1 when (src_addr+length)>DEPTH or (dst_addr+length)>DEPTH, evaluated at ADDR_W+1 bits.
REQ-024 On that start, the FSM SHALL go to READ in all other cases.
REQ-025 start SHALL be ignored outside IDLE.
REQ-026 Direction SHALL be descending when dst>src and dst<src+length; otherwise ascending.
REQ-027 Ascending copies SHALL use offsets 0..length-1 in order; descending copies SHALL use length-1..0.
REQ-028 READ SHALL drive m_chipselect=1, m_write=0, m_address=src+offset for exactly one cycle, then go to CAPTURE.
REQ-029 CAPTURE SHALL drive m_chipselect=0, register m_readdata into a 32-bit data register, then go to WRITE.
REQ-030 WRITE SHALL drive m_chipselect=1, m_write=1, m_address=dst+offset and m_writedata=data register for exactly one cycle.
REQ-031 After WRITE, the FSM SHALL go to READ if words remain, else to FINISH.
REQ-032 FINISH SHALL assert done=1 (and error per REQ-022/REQ-023) for one cycle with busy=0, then go to IDLE.
REQ-033 busy SHALL be 1 exactly in READ, CAPTURE and WRITE.
REQ-034 Each copied word SHALL take 3 cycles; a copy SHALL complete in 3*length cycles plus one FINISH cycle.
REQ-035 m_address, m_chipselect, m_write and m_writedata SHALL be registered outputs.
REQ-036 Outside READ and WRITE, m_chipselect and m_write SHALL be 0, and m_address and m_writedata SHALL hold their last values.
REQ-037 The word counter SHALL be ADDR_W bits and SHALL never wrap, because range is checked at start.
REQ-038 src=dst SHALL perform the copy normally, rewriting each word with its own value.

Reset
REQ-039 reset_n=0 SHALL immediately force state=IDLE.
REQ-040 reset_n=0 SHALL immediately force busy=0, done=0, error=0, m_chipselect=0 and m_write=0.
REQ-041 reset_n=0 SHALL immediately force m_address=0, m_writedata=0 and all internal counters and registers to 0.
REQ-042 Reset mid-copy SHALL abort with no further bus access, leaving already-written words modified.
REQ-043 The first start after reset release SHALL be accepted normally.

Verification
REQ-044 Bench: mem[100..103]=A,B,C,D; start src=100 dst=200 len=4 -> 4 reads, each followed by a write, addresses ascending; mem[200..203]=A,B,C,D; done after 13 cycles; busy high for 12 cycles.
REQ-045 Bench: mem[10..14]=1..5; start src=10 dst=12 len=5 -> descending order (first read 14, first write 16); mem[12..16]=1..5.
REQ-046 Bench: start len=0, then separately start src=10230 dst=0 len=20 -> each gives done after 1 cycle with no chipselect; error=0 for len=0 and error=1 for the overrun.
REQ-047 Bench: start pulsed again while busy during a len=3 copy -> ignored; exactly 6 accesses; exactly one done pulse.
REQ-048 Bench: assert reset_n=0 during the second WRITE of a len=4 copy -> outputs go to 0 asynchronously; only the first word was copied; a new start afterwards completes correctly.

Source files
------------

// File: rtl/nios_system_4_mem_copier.sv
`default_nettype none
// ============================================================================
// Module   : nios_system_4_mem_copier
// Brief    : Avalon-MM word copier. Each word takes a read, a capture and a write cycle.
// Revision : 1.0 - initial release
// ============================================================================
module nios_system_4_mem_copier #(
  parameter int DEPTH  = 10240,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W-1:0] length,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] m_address,
  output logic [3:0]        m_byteenable,
  output logic              m_chipselect,
  output logic              m_write,
  output logic [31:0]       m_writedata,
  output logic              m_clken,
  input  logic [31:0]       m_readdata
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    CAPTURE = 3'd2,
    WRITE   = 3'd3,
    FINISH  = 3'd4
  } state_t;

  localparam logic [ADDR_W:0]   c_depth = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] c_one   = ADDR_W'(1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] r_dst;
  logic [ADDR_W-1:0] r_offset;
  logic [ADDR_W-1:0] r_remaining;
  logic              r_desc;
  logic              r_error;
  logic [31:0]       r_data;

  logic [ADDR_W:0]   w_src_end;
  logic [ADDR_W:0]   w_dst_end;
  logic              w_range_err;
  logic              w_desc_in;
  logic [ADDR_W-1:0] w_offset_nxt;
  logic [ADDR_W-1:0] w_rd_base;

  assign m_byteenable = 4'hF;
  assign m_clken      = 1'b1;
  assign m_writedata  = r_data;
  assign busy         = (r_state == READ) || (r_state == CAPTURE) || (r_state == WRITE);
  assign done         = (r_state == FINISH);
  assign error        = (r_state == FINISH) && r_error;

  always_comb begin
    w_state_nxt  = r_state;
    w_offset_nxt = r_offset;
    w_rd_base    = r_src;
    w_src_end    = {1'b0, src_addr} + {1'b0, length};
    w_dst_end    = {1'b0, dst_addr} + {1'b0, length};
    w_range_err  = (w_src_end > c_depth) || (w_dst_end > c_depth);
    // Destination overlapping the tail of the source must be copied top-down.
    w_desc_in    = (dst_addr > src_addr) && ({1'b0, dst_addr} < w_src_end);
    case (r_state)
      IDLE: begin
        w_rd_base = src_addr;
        if (start) begin
          if (length == '0 || w_range_err) begin
            w_state_nxt = FINISH;
          end else begin
            w_state_nxt  = READ;
            w_offset_nxt = w_desc_in ? (length - c_one) : '0;
          end
        end
      end
      READ:    w_state_nxt = CAPTURE;
      CAPTURE: w_state_nxt = WRITE;
      WRITE: begin
        if (r_remaining > c_one) begin
          w_state_nxt  = READ;
          w_offset_nxt = r_desc ? (r_offset - c_one) : (r_offset + c_one);
        end else begin
          w_state_nxt = FINISH;
        end
      end
      FINISH:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_src        <= '0;
      r_dst        <= '0;
      r_offset     <= '0;
      r_remaining  <= '0;
      r_desc       <= 1'b0;
      r_error      <= 1'b0;
      r_data       <= '0;
      m_address    <= '0;
      m_chipselect <= 1'b0;
      m_write      <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_offset <= w_offset_nxt;
      if (r_state == IDLE && start) begin
        r_src       <= src_addr;
        r_dst       <= dst_addr;
        r_remaining <= length;
        r_desc      <= w_desc_in;
        r_error     <= (length != '0) && w_range_err;
      end
      if (r_state == WRITE) begin
        r_remaining <= r_remaining - c_one;
      end
      if (r_state == CAPTURE) begin
        r_data <= m_readdata;
      end
      // Bus strobes are decoded from the next state so they align with the state.
      m_chipselect <= (w_state_nxt == READ) || (w_state_nxt == WRITE);
      m_write      <= (w_state_nxt == WRITE);
      if (w_state_nxt == READ) begin
        m_address <= w_rd_base + w_offset_nxt;
      end else if (w_state_nxt == WRITE) begin
        m_address <= r_dst + r_offset;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nios_system_4_mem_copier.sv
`default_nettype none
// Bench for nios_system_4_mem_copier: bus-level memory slave plus a memmove reference model.
module tb_nios_system_4_mem_copier;

  localparam int DEPTH = 10240;
  localparam int AW    = 14;
  typedef logic [AW:0] acc_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] src_addr = '0;
  logic [AW-1:0] dst_addr = '0;
  logic [AW-1:0] length = '0;
  logic          busy, done, error, m_chipselect, m_write, m_clken;
  logic [AW-1:0] m_address;
  logic [3:0]    m_byteenable;
  logic [31:0]   m_writedata;
  logic [31:0]   m_readdata = '0;

  logic [31:0] mem     [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  acc_t        acc_q[$];
  acc_t        exp_q[$];
  int          busy_cnt, done_cnt, err_cnt, done_at;
  logic        err_at_done;
  int          total = 0;
  int          bad   = 0;

  nios_system_4_mem_copier #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
    .busy(busy), .done(done), .error(error),
    .m_address(m_address), .m_byteenable(m_byteenable), .m_chipselect(m_chipselect),
    .m_write(m_write), .m_writedata(m_writedata), .m_clken(m_clken), .m_readdata(m_readdata)
  );

  always #5 clk = ~clk;

  // On-chip memory slave: fixed read latency 1, garbage on the data bus otherwise.
  always @(posedge clk) begin
    if (m_chipselect && m_write) mem[m_address] = m_writedata;
    if (m_chipselect && !m_write) m_readdata <= mem[m_address];
    else m_readdata <= $urandom;
  end

  always @(negedge clk) begin
    if (m_chipselect) acc_q.push_back({m_write, m_address});
    if (busy) busy_cnt++;
    if (done) done_cnt++;
    if (error) err_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired got=timeout want=finish");
    $fatal(1);
  end

  // memmove semantics plus the access order the copier is expected to produce.
  task automatic model_copy(input int s, input int d, input int l, output bit e);
    logic [31:0] tmp[$];
    bit desc;
    exp_q.delete();
    e = (l != 0) && ((s + l > DEPTH) || (d + l > DEPTH));
    if (l == 0 || e) return;
    desc = (d > s) && (d < s + l);
    for (int i = 0; i < l; i++) tmp.push_back(ref_mem[s+i]);
    for (int i = 0; i < l; i++) ref_mem[d+i] = tmp[i];
    for (int k = 0; k < l; k++) begin
      int o = desc ? (l - 1 - k) : k;
      exp_q.push_back({1'b0, AW'(s + o)});
      exp_q.push_back({1'b1, AW'(d + o)});
    end
  endtask

  function automatic int acc_diffs();
    int n = (acc_q.size() > exp_q.size()) ? acc_q.size() - exp_q.size()
                                          : exp_q.size() - acc_q.size();
    for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++)
      if (acc_q[i] !== exp_q[i]) n++;
    return n;
  endfunction

  function automatic int mem_diffs();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) n++;
    return n;
  endfunction

  task automatic run_copy(input int s, input int d, input int l, input bit poke);
    @(negedge clk);
    acc_q.delete(); busy_cnt = 0; done_cnt = 0; err_cnt = 0;
    src_addr = AW'(s); dst_addr = AW'(d); length = AW'(l); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    done_at = 0; err_at_done = 1'bx;
    for (int n = 1; n <= 3*l + 20; n++) begin
      if (done) begin done_at = n; err_at_done = error; break; end
      if (poke) begin
        start    = (n % 2 == 0);
        src_addr = AW'($urandom_range(0, 50));
        dst_addr = AW'($urandom_range(60, 120));
        length   = AW'($urandom_range(1, 9));
      end
      @(negedge clk);
    end
    start = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({busy, done, error, m_chipselect, m_write} !== 5'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b want=00000", {busy, done, error, m_chipselect, m_write});
    end
    total++;
    if (m_address !== '0 || m_writedata !== '0) begin
      bad++; $display("FAIL reset_bus got=%h/%h want=0/0", m_address, m_writedata);
    end
    total++;
    if (m_byteenable !== 4'hF || m_clken !== 1'b1) begin
      bad++; $display("FAIL reset_const got=%h/%b want=f/1", m_byteenable, m_clken);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_ascending();
    logic [31:0] w[4];
    bit e;
    int n = 0;
    for (int i = 0; i < 4; i++) begin
      w[i] = $urandom; mem[100+i] = w[i]; ref_mem[100+i] = w[i];
    end
    run_copy(100, 200, 4, 1'b0);
    model_copy(100, 200, 4, e);
    total++; if (done_at !== 13) begin bad++; $display("FAIL asc_done_at got=%0d want=13", done_at); end
    total++; if (busy_cnt !== 12) begin bad++; $display("FAIL asc_busy got=%0d want=12", busy_cnt); end
    total++; if (done_cnt !== 1 || err_cnt !== 0) begin
      bad++; $display("FAIL asc_pulses got=%0d/%0d want=1/0", done_cnt, err_cnt);
    end
    total++; if (acc_diffs() !== 0) begin bad++; $display("FAIL asc_order got=%0d diffs want=0", acc_diffs()); end
    for (int i = 0; i < 4; i++) if (mem[200+i] !== w[i]) n++;
    total++; if (n !== 0) begin bad++; $display("FAIL asc_data got=%0d bad words want=0", n); end
    total++; if (mem_diffs() !== 0) begin bad++; $display("FAIL asc_mem got=%0d diffs want=0", mem_diffs()); end
  endtask

  task automatic test_descending();
    bit e;
    acc_t first_rd, first_wr;
    int n = 0;
    for (int i = 0; i < 5; i++) begin mem[10+i] = 32'(i + 1); ref_mem[10+i] = 32'(i + 1); end
    run_copy(10, 12, 5, 1'b0);
    model_copy(10, 12, 5, e);
    first_rd = (acc_q.size() > 0) ? acc_q[0] : 'x;
    first_wr = (acc_q.size() > 1) ? acc_q[1] : 'x;
    total++; if (first_rd !== {1'b0, AW'(14)} || first_wr !== {1'b1, AW'(16)}) begin
      bad++; $display("FAIL desc_first got=%h/%h want=%h/%h", first_rd, first_wr, {1'b0, AW'(14)}, {1'b1, AW'(16)});
    end
    total++; if (acc_diffs() !== 0) begin bad++; $display("FAIL desc_order got=%0d diffs want=0", acc_diffs()); end
    for (int i = 0; i < 5; i++) if (mem[12+i] !== 32'(i + 1)) n++;
    total++; if (n !== 0) begin bad++; $display("FAIL desc_data got=%0d bad words want=0", n); end
    total++; if (done_at !== 16) begin bad++; $display("FAIL desc_done_at got=%0d want=16", done_at); end
  endtask

  task automatic test_zero_and_range();
    int ts[4] = '{50, 10230, 0, 10230};
    int td[4] = '{60, 0, 10230, 0};
    int tl[4] = '{0, 20, 11, 10};
    bit e;
    int want_at;
    for (int k = 0; k < 4; k++) begin
      run_copy(ts[k], td[k], tl[k], 1'b0);
      model_copy(ts[k], td[k], tl[k], e);
      want_at = (exp_q.size() == 0) ? 1 : 3*tl[k] + 1;
      total++; if (done_at !== want_at) begin
        bad++; $display("FAIL zr%0d_done_at got=%0d want=%0d", k, done_at, want_at);
      end
      total++; if (err_at_done !== e || err_cnt !== int'(e) || done_cnt !== 1) begin
        bad++; $display("FAIL zr%0d_err got=%b/%0d/%0d want=%b/%0d/1", k, err_at_done, err_cnt, done_cnt, e, int'(e));
      end
      total++; if (acc_diffs() !== 0) begin bad++; $display("FAIL zr%0d_access got=%0d diffs want=0", k, acc_diffs()); end
      total++; if (mem_diffs() !== 0) begin bad++; $display("FAIL zr%0d_mem got=%0d diffs want=0", k, mem_diffs()); end
    end
  endtask

  task automatic test_start_while_busy();
    bit e;
    run_copy(700, 710, 3, 1'b1);
    model_copy(700, 710, 3, e);
    total++; if (acc_q.size() !== 6) begin bad++; $display("FAIL busy_start_count got=%0d want=6", acc_q.size()); end
    total++; if (acc_diffs() !== 0) begin bad++; $display("FAIL busy_start_order got=%0d diffs want=0", acc_diffs()); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL busy_start_done got=%0d want=1", done_cnt); end
    total++; if (mem_diffs() !== 0) begin bad++; $display("FAIL busy_start_mem got=%0d diffs want=0", mem_diffs()); end
  endtask

  task automatic test_reset_mid();
    bit e;
    int wr = 0;
    bit hit = 0;
    @(negedge clk);
    src_addr = AW'(300); dst_addr = AW'(400); length = AW'(4); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (m_chipselect && m_write) wr++;
      if (wr == 2) begin hit = 1; break; end
      @(negedge clk);
    end
    total++; if (hit !== 1'b1) begin bad++; $display("FAIL rstmid_reach got=%0d writes want=2", wr); end
    reset_n = 1'b0;
    #1;
    total++; if ({busy, done, error, m_chipselect, m_write} !== 5'b0) begin
      bad++; $display("FAIL rstmid_ctrl got=%b want=00000", {busy, done, error, m_chipselect, m_write});
    end
    total++; if (m_address !== '0 || m_writedata !== '0) begin
      bad++; $display("FAIL rstmid_bus got=%h/%h want=0/0", m_address, m_writedata);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    ref_mem[400] = ref_mem[300];
    total++; if (mem_diffs() !== 0) begin bad++; $display("FAIL rstmid_partial got=%0d diffs want=0", mem_diffs()); end
    run_copy(300, 400, 4, 1'b0);
    model_copy(300, 400, 4, e);
    total++; if (done_at !== 13 || acc_diffs() !== 0) begin
      bad++; $display("FAIL rstmid_restart got=%0d/%0d want=13/0", done_at, acc_diffs());
    end
    total++; if (mem_diffs() !== 0) begin bad++; $display("FAIL rstmid_mem got=%0d diffs want=0", mem_diffs()); end
  endtask

  task automatic test_random();
    int s, d, l, want_at;
    bit e;
    for (int it = 0; it < 10; it++) begin
      l = $urandom_range(0, 8);
      s = $urandom_range(1000, 1100);
      case ($urandom_range(0, 3))
        0: d = s + $urandom_range(0, l);
        1: d = s - $urandom_range(0, l);
        2: d = s;
        default: d = $urandom_range(3000, 3100);
      endcase
      run_copy(s, d, l, 1'b0);
      model_copy(s, d, l, e);
      want_at = 3*l + 1;
      total++; if (done_at !== want_at || busy_cnt !== 3*l) begin
        bad++; $display("FAIL rnd%0d_timing got=%0d/%0d want=%0d/%0d", it, done_at, busy_cnt, want_at, 3*l);
      end
      total++; if (done_cnt !== 1 || err_cnt !== 0) begin
        bad++; $display("FAIL rnd%0d_pulses got=%0d/%0d want=1/0", it, done_cnt, err_cnt);
      end
      total++; if (acc_diffs() !== 0) begin
        bad++; $display("FAIL rnd%0d_order s=%0d d=%0d l=%0d got=%0d diffs want=0", it, s, d, l, acc_diffs());
      end
      total++; if (mem_diffs() !== 0) begin bad++; $display("FAIL rnd%0d_mem got=%0d diffs want=0", it, mem_diffs()); end
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    test_reset();
    test_ascending();
    test_descending();
    test_zero_and_range();
    test_start_while_busy();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
